centroid_window_ctrl: RTL and testbench
=======================================

# centroid_window_ctrl

Parametrised window controller for the ORB centroid stage. Each accepted corner strobe opens a fixed-length enable window, so the centroid accumulators can integrate the patch that streams past that corner. The block tracks up to SLOTS overlapping windows, gives each corner a sequence tag, and reports window start, window completion and dropped corners. A retrigger mode reproduces the classic single-window behaviour.

## Interface
- WIN_LEN, 42: window length in cycles, including the corner cycle; must be ≥ 2. Counter width is CNT_W = $clog2(WIN_LEN).
- SLOTS, 4: number of concurrently tracked windows (MODE=0 only); must be ≥ 1.
- TAG_W, 8: width of the corner sequence tag.
- MODE, 0: 0 = multi-slot; 1 = retrigger (single slot, window restarts on each corner).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  advance enable; when low, all slot counters hold and corner_in is ignored
- corner_in  in  1  corner strobe, one bit per pixel cycle
- enable_out  out  1  centroid accumulate enable
- win_start  out  1  pulse: corner accepted this cycle
- start_tag  out  TAG_W  tag assigned to the accepted corner; valid with win_start
- win_done  out  1  pulse: a window's last cycle
- done_tag  out  TAG_W  tag of the completing window; valid with win_done
- active_cnt  out  $clog2(SLOTS+1)  registered count of busy slots
- drop_pulse  out  1  corner refused because no slot was free
- drop_cnt  out  16  saturating count of dropped corners

## Operation
- State per slot: counter cnt (0 = idle) and a TAG_W tag. Global state: seq (next tag), drop_cnt, active_cnt.
- accept = ena & corner_in & free, where free means some slot has cnt==0 or completes this cycle.
- On accept:
  - The lowest-index free slot is selected. A completing slot counts as free and is reusable in the same cycle.
  - The selected slot loads cnt=1 and tag=seq.
  - seq increments, modulo 2^TAG_W.
- Slot advance (ena=1, cnt≠0):
  - If cnt == WIN_LEN-1, cnt goes to 0 and win_done is raised with done_tag = that slot's tag.
  - Otherwise cnt increments.
- Only one corner can be accepted per cycle, so at most one slot completes per cycle.
- Refused corner (ena & corner_in & !free):
  - drop_pulse is raised.
  - drop_cnt increments, saturating at 16'hFFFF.
  - seq does not increment.
- enable_out = accept | (any cnt≠0). It stays high through ena stalls while any slot is active.
- MODE=1 (retrigger):
  - Only slot 0 is used.
  - A corner is never dropped.
  - A corner while active reloads cnt=1 and tag=seq; win_start pulses and seq increments.
  - The superseded window produces no win_done.
  - If a corner arrives in the same cycle slot 0 would complete, the reload wins and win_done is suppressed.
- ena=0: counters, tags, seq and drop_cnt all hold. No win_start, win_done or drop_pulse is raised.
- Reset: all cnt=0, tags=0, seq=0, drop_cnt=0, active_cnt=0.
  - While rst=1, all combinational outputs are forced to 0: enable_out, win_start, win_done, drop_pulse.
  - rst dominates a simultaneous corner_in.

## Timing
- Corner accepted at cycle t with ena held high:
  - enable_out is high for cycles t through t+WIN_LEN-1.
  - win_start and start_tag appear at t, combinationally.
  - win_done and done_tag appear at t+WIN_LEN-1, combinationally.
- Each cycle with ena=0 inside the window delays win_done by one cycle.
- active_cnt is registered: it reflects slot occupancy after the clock edge (first shows the new slot at t+1 and drops it at t+WIN_LEN).
- drop_cnt updates one cycle after drop_pulse.
- Latency from corner_in to enable_out is zero cycles.

## Test plan
- Single corner: WIN_LEN=42, corner at cycle 10 → enable_out high for cycles 10..51; win_done at 51 with done_tag=0; active_cnt=1 for cycles 11..51, then 0.
- Overflow: SLOTS=4, corners at cycles 10..14 → tags 0..3 accepted; cycle 14 gives drop_pulse and drop_cnt=1 from cycle 15; win_done at 51..54 with tags 0..3.
- Reuse on completion: SLOTS=1, corners at cycles 10 and 51 → both accepted (tags 0, 1); win_done at 51 and 92; no drop; enable_out continuous over 10..92.
- Stall: corner at cycle 10, ena=0 for cycles 20..24 with corner_in=1 at cycle 22 → win_done at 56; no drop; seq unchanged by the stalled corner; enable_out stays high.
- Retrigger: MODE=1, corners at cycles 10 and 30 → a single win_done, at cycle 71 with done_tag=1; no win_done at 51; enable_out high for 10..71.
- Reset mid-window: corner at 10, rst at cycle 30 → enable_out=0 from cycle 30; active_cnt=0 after reset; a corner after reset gets start_tag=0.

Source files
------------

// File: rtl/centroid_window_ctrl.sv
// Window controller for the ORB centroid stage: each accepted corner opens a
// WIN_LEN-cycle accumulate window, tracked in one of SLOTS tagged slots.
module centroid_window_ctrl #(
    parameter int unsigned WIN_LEN = 42,
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       corner_in,
    output logic                       enable_out,
    output logic                       win_start,
    output logic [TAG_W-1:0]           start_tag,
    output logic                       win_done,
    output logic [TAG_W-1:0]           done_tag,
    output logic [$clog2(SLOTS+1)-1:0] active_cnt,
    output logic                       drop_pulse,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned NS    = (MODE != 0) ? 1 : SLOTS;
    localparam int unsigned CNT_W = $clog2(WIN_LEN);
    localparam int unsigned AW    = $clog2(SLOTS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);

    logic [CNT_W-1:0] cnt     [NS];
    logic [CNT_W-1:0] cnt_nxt [NS];
    logic [TAG_W-1:0] tag     [NS];
    logic [TAG_W-1:0] tag_nxt [NS];
    logic [TAG_W-1:0] seq;
    logic [AW-1:0]    occ_nxt;
    logic             accept;

    always_comb begin
        logic          corner;
        logic          found;
        logic          busy;
        logic          done_raw;
        logic          last_i;
        int unsigned   sel;

        corner     = ena & corner_in & ~rst;
        found      = 1'b0;
        busy       = 1'b0;
        done_raw   = 1'b0;
        sel        = 0;
        done_tag   = '0;
        start_tag  = seq;
        occ_nxt    = '0;

        // A slot in its last cycle is already free for the incoming corner.
        for (int unsigned i = 0; i < NS; i++) begin
            last_i = ena && (cnt[i] == LAST);
            busy   = busy | (cnt[i] != '0);
            if ((cnt[i] == '0 || last_i) && !found) begin
                found = 1'b1;
                sel   = i;
            end
            if (last_i) begin
                done_raw = 1'b1;
                done_tag = tag[i];
            end
            tag_nxt[i] = tag[i];
            if (!ena || cnt[i] == '0)
                cnt_nxt[i] = cnt[i];
            else if (last_i)
                cnt_nxt[i] = '0;
            else
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end

        // Retrigger: slot 0 is always taken over by a new corner.
        if (MODE != 0) begin
            found = 1'b1;
            sel   = 0;
        end

        accept     = corner & found;
        drop_pulse = corner & ~found;

        for (int unsigned i = 0; i < NS; i++) begin
            if (accept && i == sel) begin
                cnt_nxt[i] = CNT_W'(1);
                tag_nxt[i] = seq;
            end
            if (cnt_nxt[i] != '0)
                occ_nxt = occ_nxt + AW'(1);
        end

        win_start  = accept;
        win_done   = ~rst & done_raw & ~((MODE != 0) & accept);
        enable_out = ~rst & (accept | busy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NS; i++) begin
                cnt[i] <= '0;
                tag[i] <= '0;
            end
            seq        <= '0;
            drop_cnt   <= '0;
            active_cnt <= '0;
        end else begin
            cnt        <= cnt_nxt;
            tag        <= tag_nxt;
            active_cnt <= occ_nxt;
            if (accept)
                seq <= seq + TAG_W'(1);
            if (drop_pulse && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_centroid_window_ctrl.sv
// Directed bench for centroid_window_ctrl: multi-slot, single-slot reuse and
// retrigger instances, checked cycle by cycle against hand-derived windows.
module tb_centroid_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u0: default multi-slot, u1: single slot, u2: retrigger
    logic       rst0 = 1'b1, ena0 = 1'b1, cor0 = 1'b0;
    logic       en0, ws0, wd0, dp0;
    logic [7:0] st0, dt0;
    logic [2:0] ac0;
    logic [15:0] dc0;

    logic       rst1 = 1'b1, ena1 = 1'b1, cor1 = 1'b0;
    logic       en1, ws1, wd1, dp1;
    logic [7:0] st1, dt1;
    logic [0:0] ac1;
    logic [15:0] dc1;

    logic       rst2 = 1'b1, ena2 = 1'b1, cor2 = 1'b0;
    logic       en2, ws2, wd2, dp2;
    logic [7:0] st2, dt2;
    logic [2:0] ac2;
    logic [15:0] dc2;

    centroid_window_ctrl #(.WIN_LEN(42), .SLOTS(4), .TAG_W(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst0), .ena(ena0), .corner_in(cor0), .enable_out(en0),
        .win_start(ws0), .start_tag(st0), .win_done(wd0), .done_tag(dt0),
        .active_cnt(ac0), .drop_pulse(dp0), .drop_cnt(dc0));

    centroid_window_ctrl #(.WIN_LEN(42), .SLOTS(1), .TAG_W(8), .MODE(0)) u1 (
        .clk(clk), .rst(rst1), .ena(ena1), .corner_in(cor1), .enable_out(en1),
        .win_start(ws1), .start_tag(st1), .win_done(wd1), .done_tag(dt1),
        .active_cnt(ac1), .drop_pulse(dp1), .drop_cnt(dc1));

    centroid_window_ctrl #(.WIN_LEN(42), .SLOTS(4), .TAG_W(8), .MODE(1)) u2 (
        .clk(clk), .rst(rst2), .ena(ena2), .corner_in(cor2), .enable_out(en2),
        .win_start(ws2), .start_tag(st2), .win_done(wd2), .done_tag(dt2),
        .active_cnt(ac2), .drop_pulse(dp2), .drop_cnt(dc2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with corners asserted; rst must dominate everything.
    task automatic reset_all();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        ena0 = 1'b1; ena1 = 1'b1; ena2 = 1'b1;
        cor0 = 1'b1; cor1 = 1'b1; cor2 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #4;
            check("rst en0", en0, 0);
            check("rst ws0", ws0, 0);
            check("rst dp0", dp0, 0);
            check("rst ws1", ws1, 0);
            check("rst ws2", ws2, 0);
            if (r == 1) begin
                check("rst ac0", ac0, 0);
                check("rst dc0", dc0, 0);
                check("rst ac2", ac2, 0);
            end
            tick();
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        cor0 = 1'b0; cor1 = 1'b0; cor2 = 1'b0;
    endtask

    initial begin
        #1;

        // Single corner at 10
        reset_all();
        for (int c = 0; c <= 60; c++) begin
            cor0 = (c == 10);
            #4;
            check($sformatf("single en c=%0d", c), en0, (c >= 10 && c <= 51));
            check($sformatf("single ws c=%0d", c), ws0, (c == 10));
            check($sformatf("single wd c=%0d", c), wd0, (c == 51));
            check($sformatf("single ac c=%0d", c), ac0, (c >= 11 && c <= 51));
            if (c == 10) check("single start_tag", st0, 0);
            if (c == 51) check("single done_tag", dt0, 0);
            tick();
        end

        // Overflow: corners 10..14, fifth is dropped
        reset_all();
        for (int c = 0; c <= 60; c++) begin
            int act;
            act = 0;
            for (int k = 0; k < 4; k++)
                if (c >= 11 + k && c <= 51 + k) act++;
            cor0 = (c >= 10 && c <= 14);
            #4;
            check($sformatf("ovf en c=%0d", c), en0, (c >= 10 && c <= 54));
            check($sformatf("ovf ws c=%0d", c), ws0, (c >= 10 && c <= 13));
            check($sformatf("ovf dp c=%0d", c), dp0, (c == 14));
            check($sformatf("ovf dc c=%0d", c), dc0, (c >= 15) ? 1 : 0);
            check($sformatf("ovf wd c=%0d", c), wd0, (c >= 51 && c <= 54));
            check($sformatf("ovf ac c=%0d", c), ac0, act);
            if (c >= 10 && c <= 13) check($sformatf("ovf st c=%0d", c), st0, c - 10);
            if (c >= 51 && c <= 54) check($sformatf("ovf dt c=%0d", c), dt0, c - 51);
            tick();
        end

        // Stall: ena low 20..24 with an ignored corner at 22
        reset_all();
        for (int c = 0; c <= 62; c++) begin
            ena0 = !(c >= 20 && c <= 24);
            cor0 = (c == 10 || c == 22 || c == 60);
            #4;
            check($sformatf("stall en c=%0d", c), en0, (c >= 10 && c <= 56) || c >= 60);
            check($sformatf("stall ws c=%0d", c), ws0, (c == 10 || c == 60));
            check($sformatf("stall wd c=%0d", c), wd0, (c == 56));
            check($sformatf("stall dp c=%0d", c), dp0, 0);
            check($sformatf("stall ac c=%0d", c), ac0, (c >= 11 && c <= 56) || c >= 61);
            if (c == 56) check("stall done_tag", dt0, 0);
            if (c == 60) check("stall start_tag", st0, 1);
            tick();
        end
        ena0 = 1'b1;
        check("stall dc", dc0, 0);

        // Reset mid-window at 30 (with a corner that must be ignored)
        reset_all();
        for (int c = 0; c <= 37; c++) begin
            rst0 = (c == 30);
            cor0 = (c == 10 || c == 30 || c == 35);
            #4;
            check($sformatf("mrst en c=%0d", c), en0, (c >= 10 && c <= 29) || c >= 35);
            check($sformatf("mrst ws c=%0d", c), ws0, (c == 10 || c == 35));
            check($sformatf("mrst ac c=%0d", c), ac0, (c >= 11 && c <= 30) || c >= 36);
            if (c == 35) check("mrst start_tag", st0, 0);
            tick();
        end
        rst0 = 1'b0;

        // Single-slot reuse on completion: corners 10 and 51
        reset_all();
        for (int c = 0; c <= 95; c++) begin
            cor1 = (c == 10 || c == 51);
            #4;
            check($sformatf("reuse en c=%0d", c), en1, (c >= 10 && c <= 92));
            check($sformatf("reuse ws c=%0d", c), ws1, (c == 10 || c == 51));
            check($sformatf("reuse wd c=%0d", c), wd1, (c == 51 || c == 92));
            check($sformatf("reuse dp c=%0d", c), dp1, 0);
            check($sformatf("reuse ac c=%0d", c), ac1, (c >= 11 && c <= 92));
            if (c == 51) begin
                check("reuse st51", st1, 1);
                check("reuse dt51", dt1, 0);
            end
            if (c == 92) check("reuse dt92", dt1, 1);
            tick();
        end
        check("reuse dc", dc1, 0);

        // Retrigger: 10/30 give one done at 71; 100/141 collide, done at 182
        reset_all();
        for (int c = 0; c <= 185; c++) begin
            cor2 = (c == 10 || c == 30 || c == 100 || c == 141);
            #4;
            check($sformatf("rtrg en c=%0d", c), en2, (c >= 10 && c <= 71) || (c >= 100 && c <= 182));
            check($sformatf("rtrg ws c=%0d", c), ws2, cor2);
            check($sformatf("rtrg wd c=%0d", c), wd2, (c == 71 || c == 182));
            check($sformatf("rtrg dp c=%0d", c), dp2, 0);
            if (c == 30)  check("rtrg st30", st2, 1);
            if (c == 71)  check("rtrg dt71", dt2, 1);
            if (c == 141) check("rtrg st141", st2, 3);
            if (c == 182) check("rtrg dt182", dt2, 3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
